// File: rtl/data_mem_stage.sv
// rtl/data_mem_stage.sv - MEM stage: big-endian byte RAM, load/store decode, MEM/WB register
// Loads read combinationally; stores and the MEM/WB register update on the rising clock edge.
module data_mem_stage #(
   parameter int ADDR_BITS = 8
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic [3:0]  RAM_CTRL_in,
   input  logic        L_in,
   input  logic        RF_LE_in,
   input  logic [4:0]  RD_in,
   input  logic [31:0] EX_in,
   input  logic [31:0] ST_in,
   output logic [31:0] MEM_FW,
   output logic [4:0]  RD_MEM,
   output logic        RF_LE_MEM,
   output logic [31:0] PW,
   output logic [4:0]  RW,
   output logic        RF_LE_WB,
   output logic        MISALIGN
);

   localparam int DEPTH = 2 ** ADDR_BITS;

   logic [7:0]           mem [0:DEPTH-1];
   logic [ADDR_BITS-1:0] a, a1, a2, a3;
   logic [1:0]           size;
   logic                 enable, store, aligned, active, misalign_d;
   logic [31:0]          load_data;

   assign enable = RAM_CTRL_in[3];
   assign store  = RAM_CTRL_in[2];
   assign size   = RAM_CTRL_in[1:0];

   // Aligned accesses never cross the top of the RAM, so these adds never wrap in use.
   assign a  = EX_in[ADDR_BITS-1:0];
   assign a1 = a + ADDR_BITS'(1);
   assign a2 = a + ADDR_BITS'(2);
   assign a3 = a + ADDR_BITS'(3);

   always_comb begin
      aligned = 1'b0;
      case (size)
         2'b00:   aligned = 1'b1;
         2'b01:   aligned = (a[0] == 1'b0);
         2'b10:   aligned = (a[1:0] == 2'b00);
         default: aligned = 1'b0;
      endcase
   end

   assign active     = enable && aligned;
   assign misalign_d = enable && !aligned;

   always_comb begin
      load_data = 32'h0;
      if (active) begin
         case (size)
            2'b00:   load_data = {24'b0, mem[a]};
            2'b01:   load_data = {16'b0, mem[a], mem[a1]};
            2'b10:   load_data = {mem[a], mem[a1], mem[a2], mem[a3]};
            default: load_data = 32'h0;
         endcase
      end
   end

   // RAM is not reset; a store is dropped when reset is low at its edge.
   always_ff @(posedge Clk) begin
      if (Rst && active && store) begin
         case (size)
            2'b00: mem[a] <= ST_in[7:0];
            2'b01: begin
               mem[a]  <= ST_in[15:8];
               mem[a1] <= ST_in[7:0];
            end
            2'b10: begin
               mem[a]  <= ST_in[31:24];
               mem[a1] <= ST_in[23:16];
               mem[a2] <= ST_in[15:8];
               mem[a3] <= ST_in[7:0];
            end
            default: ;
         endcase
      end
   end

   assign MEM_FW    = L_in ? load_data : EX_in;
   assign RD_MEM    = RD_in;
   assign RF_LE_MEM = RF_LE_in;

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         PW       <= 32'h0;
         RW       <= 5'd0;
         RF_LE_WB <= 1'b0;
         MISALIGN <= 1'b0;
      end else begin
         PW       <= MEM_FW;
         RW       <= RD_in;
         RF_LE_WB <= RF_LE_in;
         MISALIGN <= misalign_d;
      end
   end

endmodule

// File: tb/tb_data_mem_stage.sv
// tb/tb_data_mem_stage.sv - directed self-checking bench for data_mem_stage
module tb_data_mem_stage;

   logic        Clk = 1'b0;
   logic        Rst;
   logic [3:0]  RAM_CTRL_in;
   logic        L_in;
   logic        RF_LE_in;
   logic [4:0]  RD_in;
   logic [31:0] EX_in;
   logic [31:0] ST_in;
   logic [31:0] MEM_FW;
   logic [4:0]  RD_MEM;
   logic        RF_LE_MEM;
   logic [31:0] PW;
   logic [4:0]  RW;
   logic        RF_LE_WB;
   logic        MISALIGN;

   int total = 0;
   int bad   = 0;

   data_mem_stage #(.ADDR_BITS(8)) dut (
      .Clk(Clk), .Rst(Rst), .RAM_CTRL_in(RAM_CTRL_in), .L_in(L_in),
      .RF_LE_in(RF_LE_in), .RD_in(RD_in), .EX_in(EX_in), .ST_in(ST_in),
      .MEM_FW(MEM_FW), .RD_MEM(RD_MEM), .RF_LE_MEM(RF_LE_MEM), .PW(PW),
      .RW(RW), .RF_LE_WB(RF_LE_WB), .MISALIGN(MISALIGN)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [3:0] ctrl, input logic l, input logic le,
                        input logic [4:0] rd, input logic [31:0] ex, input logic [31:0] st);
      RAM_CTRL_in = ctrl;
      L_in        = l;
      RF_LE_in    = le;
      RD_in       = rd;
      EX_in       = ex;
      ST_in       = st;
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic mid();
      @(negedge Clk);
   endtask

   initial begin
      Rst = 1'b0;
      drive(4'b0000, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
      step();
      step();
      Rst = 1'b1;

      // preload bytes the later checks depend on
      drive(4'b1100, 1'b0, 1'b0, 5'd0, 32'h10, 32'hA5);        step();
      drive(4'b1100, 1'b0, 1'b0, 5'd0, 32'h32, 32'h00);        step();
      drive(4'b1110, 1'b0, 1'b0, 5'd0, 32'h50, 32'h01020304);  step();
      drive(4'b1110, 1'b0, 1'b0, 5'd0, 32'h40, 32'h55667788);  step();
      drive(4'b1100, 1'b0, 1'b0, 5'd0, 32'h44, 32'h99);        step();
      drive(4'b1100, 1'b0, 1'b0, 5'd0, 32'hEF, 32'h3C);        step();

      // reset with random inputs, including a byte store aimed at 0x10
      Rst = 1'b0;
      drive(4'b1100, 1'($urandom), 1'($urandom), 5'($urandom), 32'h10, $urandom);
      mid();
      check("rst_pw", PW, 32'h0);
      check("rst_rw", {27'b0, RW}, 32'h0);
      check("rst_rfle", {31'b0, RF_LE_WB}, 32'h0);
      check("rst_mis", {31'b0, MISALIGN}, 32'h0);
      step();
      drive(4'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), $urandom, $urandom);
      mid();
      check("rst_pw2", PW, 32'h0);
      step();
      Rst = 1'b1;
      drive(4'b1000, 1'b1, 1'b0, 5'd0, 32'h10, 32'h0);
      mid();
      check("rst_ram10", MEM_FW, 32'h000000A5);
      step();

      // word store then immediate load
      drive(4'b1110, 1'b0, 1'b0, 5'd0, 32'h20, 32'h11223344);  step();
      drive(4'b1010, 1'b1, 1'b1, 5'd5, 32'h20, 32'h0);
      mid();
      check("ldw_fw", MEM_FW, 32'h11223344);
      check("rd_mem", {27'b0, RD_MEM}, 32'd5);
      check("rfle_mem", {31'b0, RF_LE_MEM}, 32'd1);
      step();
      drive(4'b0000, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
      mid();
      check("ldw_pw", PW, 32'h11223344);
      check("ldw_rw", {27'b0, RW}, 32'd5);
      check("ldw_rfle", {31'b0, RF_LE_WB}, 32'd1);
      check("ldw_mis", {31'b0, MISALIGN}, 32'd0);

      // endianness
      drive(4'b1101, 1'b0, 1'b0, 5'd0, 32'h30, 32'h0000BEEF);  step();
      drive(4'b1100, 1'b0, 1'b0, 5'd0, 32'h33, 32'h0000007C);  step();
      drive(4'b1010, 1'b1, 1'b1, 5'd1, 32'h30, 32'h0);
      mid();
      check("end_ldw", MEM_FW, 32'hBEEF007C);
      step();
      drive(4'b1000, 1'b1, 1'b1, 5'd2, 32'h31, 32'h0);
      mid();
      check("end_ldb", MEM_FW, 32'h000000EF);
      check("end_pw", PW, 32'hBEEF007C);
      step();
      drive(4'b1001, 1'b1, 1'b1, 5'd3, 32'h32, 32'h0);
      mid();
      check("end_ldh", MEM_FW, 32'h0000007C);
      step();

      // misaligned word store, then misaligned halfword load
      drive(4'b1110, 1'b0, 1'b0, 5'd0, 32'h41, 32'hFFFFFFFF);  step();
      drive(4'b1001, 1'b1, 1'b1, 5'd4, 32'h43, 32'h0);
      mid();
      check("mis_st_flag", {31'b0, MISALIGN}, 32'd1);
      check("mis_ldh_fw", MEM_FW, 32'h0);
      step();
      drive(4'b1010, 1'b1, 1'b1, 5'd4, 32'h40, 32'h0);
      mid();
      check("mis_ld_flag", {31'b0, MISALIGN}, 32'd1);
      check("mis_ram40", MEM_FW, 32'h55667788);
      check("mis_ld_pw", PW, 32'h0);
      step();
      drive(4'b1000, 1'b1, 1'b1, 5'd4, 32'h44, 32'h0);
      mid();
      check("mis_clear", {31'b0, MISALIGN}, 32'd0);
      check("mis_ram44", MEM_FW, 32'h00000099);
      step();

      // reserved size reads zero and flags
      drive(4'b1011, 1'b1, 1'b0, 5'd0, 32'h20, 32'h0);
      mid();
      check("rsv_fw", MEM_FW, 32'h0);
      step();
      drive(4'b0100, 1'b0, 1'b1, 5'd9, 32'hDEADBEEF, 32'h12345678);
      mid();
      check("rsv_mis", {31'b0, MISALIGN}, 32'd1);
      check("nm_fw", MEM_FW, 32'hDEADBEEF);
      step();
      drive(4'b1000, 1'b1, 1'b0, 5'd0, 32'hEF, 32'h0);
      mid();
      check("nm_pw", PW, 32'hDEADBEEF);
      check("nm_rw", {27'b0, RW}, 32'd9);
      check("nm_rfle", {31'b0, RF_LE_WB}, 32'd1);
      check("nm_mis", {31'b0, MISALIGN}, 32'd0);
      check("nm_ramEF", MEM_FW, 32'h0000003C);
      step();

      // reset pulse across a store edge
      drive(4'b1110, 1'b0, 1'b1, 5'd7, 32'h50, 32'hCAFEF00D);
      mid();
      Rst = 1'b0;
      #1;
      check("rms_pw_async", PW, 32'h0);
      step();
      Rst = 1'b1;
      drive(4'b1010, 1'b1, 1'b1, 5'd6, 32'h50, 32'h0);
      mid();
      check("rms_ram50", MEM_FW, 32'h01020304);
      check("rms_pw", PW, 32'h0);
      step();
      drive(4'b0000, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
      mid();
      check("rel_pw", PW, 32'h01020304);
      check("rel_rw", {27'b0, RW}, 32'd6);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
